byte_serializer: RTL and testbench
==================================

# byte_serializer

Parallel-to-serial front end for the serial parity checker. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line `x`. It marks the first and last bit of each frame and optionally appends a parity bit. Its `x` output drives the serial input of the downstream parity FSM directly.

## Interface
- `WIDTH`, 8, data word width; legal range 2..32.
- `MSB_FIRST`, 1, 1 = shift the MSB out first, 0 = shift the LSB out first.
- `GAP_CYCLES`, 1, idle cycles forced after each frame; legal range 0..15.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low. Low forces all state to reset values immediately.
- `data_in`  in  WIDTH  word to serialize; sampled only on an accepted handshake.
- `data_valid`  in  1  upstream has a word on `data_in`.
- `data_ready`  out  1  block can accept a word; high only in IDLE.
- `x`  out  1  serial bit; 0 when `bit_valid` is low.
- `bit_valid`  out  1  `x` carries a frame bit this cycle.
- `frame_start`  out  1  high with the first bit of a frame only.
- `frame_end`  out  1  high with the last bit of a frame only.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, PAR (only with the macro), GAP.
- All outputs are decoded from registered state. No combinational path runs from inputs to outputs.
- IDLE:
  - `data_ready`=1, `busy`=0, `bit_valid`=0, `x`=0.
  - Accept occurs when `data_valid` && `data_ready` at a rising edge.
  - On accept: load the shift register with `data_in`, clear the bit counter, go to SHIFT.
- SHIFT:
  - `x` = current head bit of the shift register (MSB or LSB per `MSB_FIRST`); `bit_valid`=1.
  - `frame_start`=1 when counter==0.
  - At each edge: shift by one, counter+1.
  - After the edge where counter==WIDTH-1: go to PAR if the macro is enabled; else go to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES==0).
- PAR: `x` = XOR of all WIDTH bits of the captured word; `bit_valid`=1; one cycle, then GAP or IDLE.
- GAP: all bit outputs 0; a counter runs GAP_CYCLES cycles, then the block returns to IDLE.
- `frame_end`=1 on the final bit of the frame: the last data bit without the macro, the parity bit with it.
- `data_valid` and `data_in` are ignored outside IDLE. Changes to them mid-frame never affect `x`.
- Counter widths: bit counter is ceil(log2(WIDTH)) bits; gap counter is 4 bits. Neither counter wraps within a frame.
- Reset values: state=IDLE, shift register=0, counters=0.
  - Resulting outputs: `data_ready`=1, `busy`=0, `x`=0, `bit_valid`=0, `frame_start`=0, `frame_end`=0.
  - No accept takes place while `reset` is low.
- Reset mid-frame: the partial frame is discarded and outputs take reset values immediately (asynchronously). No `frame_end` is produced for the aborted frame.

## Timing
- Accept at edge N: first bit valid in the cycle after edge N. Bit k is valid in the cycle after edge N+k.
- Frame length L = WIDTH, or WIDTH+1 with the macro.
- `data_ready` is low for L+GAP_CYCLES cycles after the accept edge.
- Minimum spacing between frames: GAP_CYCLES+1 cycles with `bit_valid` low (GAP_CYCLES gap cycles plus 1 IDLE accept cycle).
- Maximum throughput: one word per L+GAP_CYCLES+1 cycles.
- `frame_start` and `frame_end` are both single-cycle pulses.

## Configuration
- `SERIALIZER_PARITY_APPEND_EN`
- Defined:
  - PAR state is present; each frame carries WIDTH data bits plus one even-parity bit (XOR of the data bits).
  - `frame_end` marks the parity bit.
- Undefined:
  - PAR state and parity logic are absent; frame is exactly WIDTH bits.
  - `frame_end` marks the last data bit.

## Test plan
- Default parameters, macro off; `reset` released, send 8'hA5:
  - `x` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, with `bit_valid` high for all 8.
  - `frame_start` on bit 1 only, `frame_end` on bit 8 only.
  - `data_ready` low for 9 cycles, then high.
- Macro on, send 8'h07:
  - `x` = 0,0,0,0,0,1,1,1,1 (the final 1 is the parity bit).
  - `frame_end` on the 9th bit; `data_ready` low for 10 cycles.
- GAP_CYCLES=0, `data_valid` held high with 8'hFF then 8'h00:
  - Exactly one cycle with `bit_valid`=0 between the two frames.
  - Second frame's bits are all 0.
- Pull `reset` low during bit 4 of 8'hA5:
  - `x`, `bit_valid`, `busy` go to 0 and `data_ready` to 1 immediately, with no `frame_end` pulse.
  - After release, a new 8'h3C serializes correctly as 0,0,1,1,1,1,0,0.
- Toggle `data_valid` and change `data_in` every cycle during a frame of 8'hA5: the serial sequence is unchanged and no extra accept occurs.
- MSB_FIRST=0, send 8'h01: `x` = 1 followed by seven 0s.

Source files
------------

// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
//
// Parallel-to-serial front end for the serial parity checker. A WIDTH-bit word
// is accepted over a valid/ready handshake while idle and is then shifted out
// one bit per clock on `x`. The first and last bits of each frame are marked
// with single-cycle pulses. An even-parity bit can optionally be appended.
// After each frame the block stays in a gap state for GAP_CYCLES cycles.
//
// Optional feature macro: SERIALIZER_PARITY_APPEND_EN
//   defined   -> PAR state present; the frame is WIDTH data bits plus one even
//                parity bit, and frame_end marks the parity bit.
//   undefined -> the frame is exactly WIDTH bits, and frame_end marks the last
//                data bit.
//
// Parameters:
//   WIDTH       word width, 2..32
//   MSB_FIRST   1 = MSB is shifted out first, 0 = LSB is shifted out first
//   GAP_CYCLES  idle cycles forced after each frame, 0..15
//
// Ports:
//   clk          clock; all state updates on its rising edge
//   reset        asynchronous, active-low reset
//   data_in      word to serialize, sampled only on an accepted handshake
//   data_valid   upstream has a word on data_in
//   data_ready   block can accept a word (IDLE only)
//   x            serial bit; 0 whenever bit_valid is low
//   bit_valid    x carries a frame bit this cycle
//   frame_start  pulse with the first bit of a frame
//   frame_end    pulse with the last bit of a frame
//   busy         high in any state other than IDLE
// -----------------------------------------------------------------------------
module byte_serializer #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam bit                HAS_GAP  = (GAP_CYCLES > 0);
    // Last gap-counter value; only reachable when HAS_GAP is set.
    localparam logic [3:0]        GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SERIALIZER_PARITY_APPEND_EN
        ST_PAR   = 2'd3,
`endif
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_reg,   state_next;
    logic [WIDTH-1:0]   shift_reg,   shift_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [3:0]         gap_cnt_reg, gap_cnt_next;
`ifdef SERIALIZER_PARITY_APPEND_EN
    logic               parity_reg,  parity_next;
`endif

    // State where the block goes once the last frame bit has been sent.
    state_t             after_frame;
    logic               head_bit;

    assign after_frame = HAS_GAP ? ST_GAP : ST_IDLE;
    assign head_bit    = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
`ifdef SERIALIZER_PARITY_APPEND_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
`ifdef SERIALIZER_PARITY_APPEND_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
`ifdef SERIALIZER_PARITY_APPEND_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (data_valid) begin
                    shift_next   = data_in;
                    bit_cnt_next = '0;
`ifdef SERIALIZER_PARITY_APPEND_EN
                    // Parity comes from the captured word, so later changes
                    // on data_in cannot disturb it.
                    parity_next  = ^data_in;
`endif
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Zeros are shifted in behind the head bit.
                shift_next = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], 1'b0}
                                              : {1'b0, shift_reg[WIDTH-1:1]};
                if (bit_cnt_reg == LAST_BIT) begin
                    // Counter holds at its last value instead of wrapping;
                    // it is cleared on the next accept.
                    gap_cnt_next = '0;
`ifdef SERIALIZER_PARITY_APPEND_EN
                    state_next   = ST_PAR;
`else
                    state_next   = after_frame;
`endif
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
`ifdef SERIALIZER_PARITY_APPEND_EN
            ST_PAR: begin
                state_next = after_frame;
            end
`endif
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Decoded from registered state only; no input reaches an output.
    always_comb begin
        data_ready  = (state_reg == ST_IDLE);
        busy        = (state_reg != ST_IDLE);
        bit_valid   = 1'b0;
        x           = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_reg)
            ST_SHIFT: begin
                bit_valid   = 1'b1;
                x           = head_bit;
                frame_start = (bit_cnt_reg == '0);
`ifndef SERIALIZER_PARITY_APPEND_EN
                frame_end   = (bit_cnt_reg == LAST_BIT);
`endif
            end
`ifdef SERIALIZER_PARITY_APPEND_EN
            ST_PAR: begin
                bit_valid = 1'b1;
                x         = parity_reg;
                frame_end = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_byte_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for byte_serializer. Three instances share clock and reset:
//   0: defaults (MSB first, one gap cycle)
//   1: GAP_CYCLES = 0
//   2: MSB_FIRST  = 0
// Expected serial bits are pushed to a queue when a word is driven and popped
// by a monitor whenever the selected instance presents a bit.
// -----------------------------------------------------------------------------
module tb_byte_serializer;

`ifdef SERIALIZER_PARITY_APPEND_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int W = 8;
    localparam int L = W + PAR_BITS;

    logic       clk;
    logic       reset;
    logic [7:0] din_r [3];
    logic       dv_r  [3];
    logic       ready_w[3], x_w[3], bv_w[3], fs_w[3], fe_w[3], busy_w[3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        byte_serializer #(
            .WIDTH     (W),
            .MSB_FIRST ((gi == 2) ? 0 : 1),
            .GAP_CYCLES((gi == 1) ? 0 : 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .data_in    (din_r[gi]),
            .data_valid (dv_r[gi]),
            .data_ready (ready_w[gi]),
            .x          (x_w[gi]),
            .bit_valid  (bv_w[gi]),
            .frame_start(fs_w[gi]),
            .frame_end  (fe_w[gi]),
            .busy       (busy_w[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic int gap_of(input int s);
        return (s == 1) ? 0 : 1;
    endfunction

    // ------------------------------------------------------------ scoreboard
    typedef struct packed {
        logic x;
        logic fs;
        logic fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   sel    = 0;
    logic mon_en = 1'b0;

    // seq holds the data bits in transmission order, first bit in seq[7].
    task automatic push_frame(input logic [7:0] seq, input logic par);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.x  = seq[7-i];
            e.fs = (i == 0);
            e.fe = (PAR_BITS == 0) && (i == W - 1);
            exp_q.push_back(e);
        end
        if (PAR_BITS != 0) begin
            e.x  = par;
            e.fs = 1'b0;
            e.fe = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bv_w[sel]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit dut=%0d got x=%b want no bit t=%0t",
                             sel, x_w[sel], $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("bit_x_fs_fe", {29'd0, x_w[sel], fs_w[sel], fe_w[sel]},
                        {29'd0, mon_e});
                end
            end else begin
                chk("idle_x_fs_fe", {29'd0, x_w[sel], fs_w[sel], fe_w[sel]}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic send(input int s, input logic [7:0] d, input logic [7:0] seq,
                        input logic par, input bit do_push);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready_w[s] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("ready_timeout", 32'd0, 32'd1);
        din_r[s] = d;
        dv_r[s]  = 1'b1;
        if (do_push) push_frame(seq, par);
        $display("txn dut=%0d data=%02h", s, d);
        @(posedge clk);
        #1;
        dv_r[s]  = 1'b0;
        din_r[s] = 8'($urandom);
    endtask

    // Counts cycles with data_ready low after an accept.
    task automatic wait_ready(input int s, output int low);
        low = 0;
        forever begin
            @(negedge clk);
            if (ready_w[s] || low >= 200) break;
            low++;
        end
    endtask

    typedef struct {
        int         s;
        logic [7:0] data;
        logic [7:0] seq;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int low, seen, lows;
        bit acc2;

        vecs[0] = '{0, 8'h3C, 8'b00111100, 1'b0};
        vecs[1] = '{0, 8'hA5, 8'b10100101, 1'b0};
        vecs[2] = '{0, 8'h07, 8'b00000111, 1'b1};
        vecs[3] = '{2, 8'h01, 8'b10000000, 1'b1};
        vecs[4] = '{2, 8'h0E, 8'b01110000, 1'b1};
        vecs[5] = '{1, 8'h5A, 8'b01011010, 1'b0};
        vecs[6] = '{0, 8'hC1, 8'b11000001, 1'b1};
        vecs[7] = '{2, 8'hA5, 8'b10100101, 1'b0};

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_r[i] = 8'h00;
            dv_r[i]  = 1'b0;
        end

        // Reset state, and no accept while reset is low.
        repeat (2) @(negedge clk);
        dv_r[0]  = 1'b1;
        din_r[0] = 8'hFF;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {26'd0, ready_w[0], busy_w[0], x_w[0], bv_w[0], fs_w[0], fe_w[0]},
            {26'd0, 6'b100000});
        dv_r[0] = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        chk("no_accept_in_reset", {31'd0, busy_w[0]}, 32'd0);

        // Reset during bit 4 of A5: frame discarded at once.
        sel = 0;
        send(0, 8'hA5, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_abort_bit4", {30'd0, bv_w[0], x_w[0]}, {30'd0, 2'b10});
        reset = 1'b0;
        #1;
        chk("abort_outputs", {26'd0, ready_w[0], busy_w[0], x_w[0], bv_w[0], fs_w[0], fe_w[0]},
            {26'd0, 6'b100000});
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_frame_end", {31'd0, fe_w[0]}, 32'd0);
        end
        reset  = 1'b1;
        mon_en = 1'b1;

        // Table-driven frames.
        foreach (vecs[i]) begin
            sel = vecs[i].s;
            send(vecs[i].s, vecs[i].data, vecs[i].seq, vecs[i].par, 1'b1);
            wait_ready(vecs[i].s, low);
            chk("ready_low_cycles", low, L + gap_of(vecs[i].s));
            chk("frame_all_bits", exp_q.size(), 32'd0);
        end

        // GAP_CYCLES=0 with data_valid held high: FF then 00 back to back.
        sel = 1;
        @(negedge clk);
        din_r[1] = 8'hFF;
        dv_r[1]  = 1'b1;
        push_frame(8'hFF, 1'b0);
        $display("txn dut=1 data=FF (valid held)");
        @(posedge clk);
        #1;
        din_r[1] = 8'h00;
        push_frame(8'h00, 1'b0);
        $display("txn dut=1 data=00 (valid held)");
        seen = 0;
        lows = 0;
        acc2 = 1'b0;
        for (int c = 0; c < 60 && seen < 2 * L; c++) begin
            @(negedge clk);
            if (bv_w[1]) seen++;
            else if (seen > 0) lows++;
            if (ready_w[1] && !acc2) begin
                acc2 = 1'b1;
                @(posedge clk);
                #1;
                dv_r[1] = 1'b0;
            end
        end
        chk("b2b_bits_seen", seen, 2 * L);
        chk("b2b_gap_cycles", lows, 32'd1);
        repeat (3) @(negedge clk);
        chk("b2b_queue_empty", exp_q.size(), 32'd0);

        // Toggle data_valid/data_in during a frame of A5.
        sel = 0;
        send(0, 8'hA5, 8'b10100101, 1'b0, 1'b1);
        low = 0;
        forever begin
            @(negedge clk);
            if (ready_w[0] || low >= 200) break;
            low++;
            dv_r[0]  = 1'($urandom);
            din_r[0] = 8'($urandom);
        end
        dv_r[0] = 1'b0;
        chk("toggle_ready_low", low, L + 1);
        repeat (12) @(negedge clk);
        chk("toggle_no_extra_accept", {31'd0, busy_w[0]}, 32'd0);
        chk("toggle_queue_empty", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
